// File: rtl/seq_mult16.sv
// Sequential 16x16 shift-and-add multiplier (unsigned / two's complement) driving a
// two-level carry-lookahead adder, one 16-bit add per iteration.

module CLA2Lvl (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        ci_i,
   output logic [15:0] s_o,
   output logic        co_o
);

   logic [15:0] gBit;
   logic [15:0] pBit;
   logic [3:0]  gGrp;
   logic [3:0]  pGrp;
   logic [4:0]  cGrp;
   logic [15:0] cBit;

   // Bit and group generate/propagate, then group carries fully expanded (second level).
   always_comb begin
      gBit = a_i & b_i;
      pBit = a_i ^ b_i;
      for (int j = 0; j < 4; j++) begin
         gGrp[j] = gBit[4*j+3]
                 | (pBit[4*j+3] & gBit[4*j+2])
                 | (pBit[4*j+3] & pBit[4*j+2] & gBit[4*j+1])
                 | (pBit[4*j+3] & pBit[4*j+2] & pBit[4*j+1] & gBit[4*j]);
         pGrp[j] = &pBit[4*j +: 4];
      end
      cGrp[0] = ci_i;
      cGrp[1] = gGrp[0] | (pGrp[0] & ci_i);
      cGrp[2] = gGrp[1] | (pGrp[1] & gGrp[0]) | (pGrp[1] & pGrp[0] & ci_i);
      cGrp[3] = gGrp[2] | (pGrp[2] & gGrp[1]) | (pGrp[2] & pGrp[1] & gGrp[0])
              | (pGrp[2] & pGrp[1] & pGrp[0] & ci_i);
      cGrp[4] = gGrp[3] | (pGrp[3] & gGrp[2]) | (pGrp[3] & pGrp[2] & gGrp[1])
              | (pGrp[3] & pGrp[2] & pGrp[1] & gGrp[0])
              | (pGrp[3] & pGrp[2] & pGrp[1] & pGrp[0] & ci_i);
      for (int j = 0; j < 4; j++) begin
         cBit[4*j]   = cGrp[j];
         cBit[4*j+1] = gBit[4*j] | (pBit[4*j] & cGrp[j]);
         cBit[4*j+2] = gBit[4*j+1] | (pBit[4*j+1] & gBit[4*j])
                     | (pBit[4*j+1] & pBit[4*j] & cGrp[j]);
         cBit[4*j+3] = gBit[4*j+2] | (pBit[4*j+2] & gBit[4*j+1])
                     | (pBit[4*j+2] & pBit[4*j+1] & gBit[4*j])
                     | (pBit[4*j+2] & pBit[4*j+1] & pBit[4*j] & cGrp[j]);
      end
      s_o  = pBit ^ cBit;
      co_o = cGrp[4];
   end

endmodule

module seq_mult16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        tc,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] p
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q;
   logic [15:0] m_q;
   logic [15:0] h_q;
   logic [15:0] l_q;
   logic [3:0]  cnt_q;
   logic        mode_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] p_q;

   logic        lastIter;
   logic        subtract;
   logic [15:0] opB;
   logic [15:0] addSum;
   logic        addCo;
   logic [16:0] sum_d;
   logic [15:0] h_d;
   logic [15:0] l_d;

   // Final signed step subtracts M: the multiplier MSB carries negative weight.
   always_comb begin
      lastIter = (cnt_q == 4'd15);
      subtract = l_q[0] & mode_q & lastIter;
      opB      = l_q[0] ? (subtract ? ~m_q : m_q) : 16'h0000;
   end

   CLA2Lvl uAdder (
      .a_i  (h_q),
      .b_i  (opB),
      .ci_i (subtract),
      .s_o  (addSum),
      .co_o (addCo)
   );

   always_comb begin
      sum_d = {(mode_q ? (h_q[15] ^ opB[15] ^ addCo) : addCo), addSum};
      h_d   = sum_d[16:1];
      l_d   = {sum_d[0], l_q[15:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         h_q     <= '0;
         l_q     <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         p_q     <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  m_q     <= a;
                  h_q     <= '0;
                  l_q     <= b;
                  cnt_q   <= '0;
                  mode_q  <= tc;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               h_q   <= h_d;
               l_q   <= l_d;
               cnt_q <= cnt_q + 4'd1;
               if (lastIter) begin
                  p_q     <= {h_d, l_d};
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;

endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: directed table, protocol corner cases and
// randomized operands against an arithmetic reference product.

module tb_seq_mult16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        tc = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy;
   logic        done;
   logic [31:0] p;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;

   typedef struct {
      string       name;
      logic        tc;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] expP;
   } vec_t;

   seq_mult16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .tc    (tc),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   // Product as plain integer arithmetic on the operands' numeric values.
   function automatic logic [31:0] refProd(input logic t, input logic [15:0] x, input logic [15:0] y);
      longint sx;
      longint sy;
      longint pr;
      sx = t ? longint'($signed(x)) : longint'(x);
      sy = t ? longint'($signed(y)) : longint'(y);
      pr = sx * sy;
      return pr[31:0];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Waits for done, counting negedges after the start edge (k=16 means done after E16).
   task automatic waitDone(input bit dropStart, output int k, output logic [31:0] pMid);
      bit seen;
      seen = 0;
      k = 0;
      pMid = 'x;
      while (!seen && k <= 40) begin
         @(negedge clk);
         if (dropStart) begin
            start = 1'b0;
            if (k == 3) begin
               a  = 16'($urandom);
               b  = 16'($urandom);
               tc = ~tc;
            end
         end
         if (k == 8) pMid = p;
         if (done) seen = 1;
         else k++;
      end
   endtask

   task automatic applyStimulus(input string name, input logic t, input logic [15:0] x,
                                input logic [15:0] y, input logic [31:0] expP);
      logic [31:0] prevP;
      logic [31:0] pMid;
      int k;
      @(negedge clk);
      prevP = p;
      tc    = t;
      a     = x;
      b     = y;
      start = 1'b1;
      waitDone(1, k, pMid);
      checkOutput({name, " latency"}, 32'(k), 32'd16);
      checkOutput({name, " product"}, p, expP);
      checkOutput({name, " busy at done"}, {31'b0, busy}, 32'd0);
      checkOutput({name, " p held mid-run"}, pMid, prevP);
      @(negedge clk);
      checkOutput({name, " done width"}, {31'b0, done}, 32'd0);
      checkOutput({name, " p after done"}, p, expP);
   endtask

   initial begin
      vec_t        vecs[$];
      int          k;
      logic [31:0] pMid;
      logic        t;
      logic [15:0] x;
      logic [15:0] y;
      int          lastCycle;

      vecs.push_back('{"unsigned max",   1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001});
      vecs.push_back('{"signed -1x3",    1'b1, 16'hFFFF, 16'h0003, 32'hFFFFFFFD});
      vecs.push_back('{"signed min^2",   1'b1, 16'h8000, 16'h8000, 32'h40000000});
      vecs.push_back('{"signed max*min", 1'b1, 16'h7FFF, 16'h8000, 32'hC0008000});
      vecs.push_back('{"unsigned zero",  1'b0, 16'h1234, 16'h0000, 32'h00000000});
      vecs.push_back('{"signed ident",   1'b1, 16'h0001, 16'hFEDC, 32'hFFFFFEDC});
      vecs.push_back('{"unsigned 8000^2",1'b0, 16'h8000, 16'h8000, 32'h40000000});
      vecs.push_back('{"signed -1x-1",   1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001});

      #1;
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset done", {31'b0, done}, 32'd0);
      checkOutput("reset p", p, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i])
         applyStimulus(vecs[i].name, vecs[i].tc, vecs[i].a, vecs[i].b, vecs[i].expP);

      // start pulsed mid-run with new operands must be ignored
      @(negedge clk);
      tc = 1'b0; a = 16'd100; b = 16'd200; start = 1'b1;
      k = 0;
      pMid = 0;
      while (pMid == 0 && k <= 40) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (k == 5) begin start = 1'b1; a = 16'd7; b = 16'd9; end
         if (k == 6) start = 1'b0;
         if (done) pMid = 1;
         else k++;
      end
      checkOutput("mid-run start latency", 32'(k), 32'd16);
      checkOutput("mid-run start product", p, 32'd20000);
      @(negedge clk);

      // start held high: back-to-back runs every 17 cycles
      t = 1'b1; x = 16'h1357; y = 16'h9ABC;
      tc = t; a = x; b = y; start = 1'b1;
      lastCycle = 0;
      for (int r = 0; r < 3; r++) begin
         waitDone(0, k, pMid);
         checkOutput($sformatf("held start r%0d latency", r), 32'(k), 32'd16);
         checkOutput($sformatf("held start r%0d product", r), p, refProd(t, x, y));
         if (r > 0) checkOutput($sformatf("held start r%0d period", r), 32'(cycle - lastCycle), 32'd17);
         lastCycle = cycle;
         t = ~t; x = x + 16'h1111; y = y ^ 16'h0F0F;
         tc = t; a = x; b = y;
         if (r == 2) start = 1'b0;
      end
      @(negedge clk);

      // asynchronous reset in the middle of a run
      tc = 1'b0; a = 16'd3; b = 16'd5; start = 1'b1;
      for (int n = 0; n <= 8; n++) begin
         @(negedge clk);
         if (n == 0) start = 1'b0;
      end
      checkOutput("pre-reset busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid-run reset busy", {31'b0, busy}, 32'd0);
      checkOutput("mid-run reset done", {31'b0, done}, 32'd0);
      checkOutput("mid-run reset p", p, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("after reset", 1'b1, 16'hFFFE, 16'h7FFF, refProd(1'b1, 16'hFFFE, 16'h7FFF));

      for (int i = 0; i < 1500; i++) begin
         t = 1'($urandom);
         x = 16'($urandom);
         y = 16'($urandom);
         if (i % 2 == 1) y[15] = 1'b1;
         applyStimulus($sformatf("rand%0d tc=%0d %h*%h", i, t, x, y), t, x, y, refProd(t, x, y));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
